dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder (target end) of the pipeline's stb/cyc/write/byte-enable data-memory interface.
- Accepts single-word requests from the memory stage and holds them in a small word-addressed SRAM.
- Completes each request with a one-cycle dmem_resp pulse after a fixed, parameterised latency.
- Serves as the data-cache stand-in for pipeline bring-up and as the bus-model target for stall-logic verification.

Parameters:
ADDR_BITS, 8, word-address width; storage depth = 2**ADDR_BITS 16-bit words.
LATENCY, 2, cycles from request accept to dmem_resp pulse; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
dmem_action_cyc  input  1  bus cycle active; deassertion aborts an in-flight request
dmem_action_stb  input  1  request strobe
dmem_write  input  1  1 = write, 0 = read
dmem_byte_enable  input  2  [0] low byte, [1] high byte (writes only)
dmem_address  input  16  byte address; bit 0 ignored for word selection
dmem_wdata  input  16  write data
dmem_rdata  output  16  read data, valid while dmem_resp = 1
dmem_resp  output  1  completion pulse, exactly one cycle per completed request

Behaviour:
- Reset is asynchronous and active-high. It forces state IDLE, dmem_resp = 0, dmem_rdata = 0x0000 and latency counter = 0. SRAM contents are not reset.
- State IDLE:
  - Accept when cyc & stb are both 1 at a clock edge.
  - On accept, latch word index = address[ADDR_BITS:1], plus write, byte_enable and wdata.
  - Load counter = LATENCY-1, go to WAIT.
- State WAIT:
  - If cyc = 0 at an edge: abort. Go to IDLE; no resp, no write, rdata unchanged.
  - Else if counter = 0: perform the access and go to RESP.
  - Else: decrement counter.
  - Latched request fields are used throughout; input changes during WAIT are ignored.
  - Net effect: resp is high in the LATENCY-th cycle after the accept edge. With LATENCY = 1, resp is high the cycle immediately after the accept cycle.
- Access, on the WAIT-to-RESP edge:
  - Write: low byte written iff be[0], high byte written iff be[1]. be = 00 writes nothing but still responds. rdata is unchanged.
  - Read: rdata loaded with the full 16-bit word; byte enables are ignored.
- State RESP:
  - dmem_resp = 1 for this single cycle, then go to IDLE unconditionally.
  - No accept in the RESP cycle. The initiator's still-asserted stb in that cycle is not treated as a new request.
  - A request held or presented in the cycle after RESP is accepted normally. This supports back-to-back indirect (LDI/STI) second accesses.
- dmem_rdata holds its last value outside RESP.
- Address aliasing: address bits above ADDR_BITS are ignored when the optional feature is absent.
- Throughput: maximum one request per LATENCY+2 cycles. No pipelining; exactly one request outstanding.
- Write is committed in the same cycle that resp is seen, so a read issued after resp returns the new data.

Optional Feature:
Macro: DMEM_RESPONDER_OOR_ERR_EN
- Defined:
  - Adds output port dmem_err (1 bit, reset 0).
  - A request with any of address[15:ADDR_BITS+1] nonzero is out-of-range. It follows the same IDLE/WAIT timing.
  - In its final cycle, dmem_err pulses for one cycle instead of dmem_resp. No write occurs and rdata is forced to 0x0000.
  - Abort and reset rules are identical to a normal request.
- Undefined:
  - No dmem_err port.
  - Out-of-range addresses alias into the SRAM and complete with dmem_resp.

Test Plan:
1. LATENCY=2: write 0xBEEF to 0x0010 with be=11 (accept at cycle t) -> resp high at t+2 only. Then read 0x0010 -> rdata=0xBEEF with resp.
2. After test 1: stb write to 0x0011, be=10, wdata=0x4400 -> read of 0x0010 returns 0x44EF. Then be=00 write of 0x1234 -> resp pulses, word stays 0x44EF.
3. Indirect sequence: 0x0020 preloaded with 0x0030, 0x0030 preloaded with 0x5A5A. Read 0x0020 -> resp with 0x0030. Stb held high, address switched to 0x0030 the cycle after resp -> accepted that cycle, second resp LATENCY cycles later with 0x5A5A. Exactly two resp pulses total.
4. Abort: write 0xFFFF to 0x0040 accepted, cyc dropped one cycle later (LATENCY=3) -> no resp ever. Word at 0x0040 unchanged (prior value 0x0000 reads back).
5. Reset mid-WAIT: assert rst asynchronously (between edges) -> resp=0 and rdata=0 immediately. After release, a read of 0x0010 completes normally at the full latency.
6. With DMEM_RESPONDER_OOR_ERR_EN, ADDR_BITS=8: write to 0x0400 -> dmem_err pulses at t+LATENCY, no resp, word 0x0000 unchanged. A read of 0x0400 returns rdata=0x0000 with err.

Source files
------------

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Target end of the stb/cyc/write/byte-enable data-memory bus.
//            Single outstanding request, fixed LATENCY cycles from accept to
//            a one-cycle dmem_resp pulse, backed by a 2**ADDR_BITS x 16 SRAM.
// Options  : DMEM_RESPONDER_OOR_ERR_EN - adds dmem_err; requests with address
//            bits above ADDR_BITS set complete with dmem_err, no write and
//            rdata forced to zero. Undefined: those addresses alias.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
   parameter int ADDR_BITS = 8,
   parameter int LATENCY   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dmem_action_cyc,
   input  logic        dmem_action_stb,
   input  logic        dmem_write,
   input  logic [1:0]  dmem_byte_enable,
   input  logic [15:0] dmem_address,
   input  logic [15:0] dmem_wdata,
   output logic [15:0] dmem_rdata,
`ifdef DMEM_RESPONDER_OOR_ERR_EN
   output logic        dmem_err,
`endif
   output logic        dmem_resp
);

   localparam int         c_DEPTH  = 1 << ADDR_BITS;
   localparam logic [3:0] c_LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                 r_state;
   logic [3:0]             r_cnt;
   logic [ADDR_BITS-1:0]   r_idx;
   logic                   r_write;
   logic [1:0]             r_be;
   logic [15:0]            r_wdata;
   logic [15:0]            r_mem [0:c_DEPTH-1];

   logic                   w_accept;
   logic                   w_access;
   logic                   w_mem_we;
   logic                   w_oor;

   // Bit 0 is a byte select the word-wide SRAM never needs.
   logic                   w_unused_addr;
   assign w_unused_addr = dmem_address[0];

   // A request is accepted only from IDLE; RESP deliberately ignores stb.
   assign w_accept = (r_state == S_IDLE) && dmem_action_cyc && dmem_action_stb;

   // The access happens on the WAIT-to-RESP edge; cyc low there is an abort.
   assign w_access = (r_state == S_WAIT) && dmem_action_cyc && (r_cnt == 4'd0);

   // Upper address bits beyond the SRAM index mark an out-of-range request.
   assign w_oor = |(dmem_address >> (ADDR_BITS + 1));

`ifdef DMEM_RESPONDER_OOR_ERR_EN
   logic r_oor;

   // Latch the range verdict with the rest of the request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_oor <= 1'b0;
      end else if (w_accept) begin
         r_oor <= w_oor;
      end
   end

   assign w_mem_we = w_access && r_write && !r_oor;
`else
   logic w_unused_oor;
   assign w_unused_oor = w_oor;
   assign w_mem_we     = w_access && r_write;
`endif

   // Request sequencing: accept, count down the latency, respond once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_idx      <= '0;
         r_write    <= 1'b0;
         r_be       <= 2'b00;
         r_wdata    <= 16'h0000;
         dmem_rdata <= 16'h0000;
         dmem_resp  <= 1'b0;
`ifdef DMEM_RESPONDER_OOR_ERR_EN
         dmem_err   <= 1'b0;
`endif
      end else begin
         dmem_resp <= 1'b0;
`ifdef DMEM_RESPONDER_OOR_ERR_EN
         dmem_err  <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_idx   <= dmem_address[ADDR_BITS:1];
                  r_write <= dmem_write;
                  r_be    <= dmem_byte_enable;
                  r_wdata <= dmem_wdata;
                  r_cnt   <= c_LAT_M1;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (!dmem_action_cyc) begin
                  r_state <= S_IDLE;
               end else if (r_cnt == 4'd0) begin
                  r_state <= S_RESP;
`ifdef DMEM_RESPONDER_OOR_ERR_EN
                  if (r_oor) begin
                     dmem_err   <= 1'b1;
                     dmem_rdata <= 16'h0000;
                  end else begin
                     dmem_resp <= 1'b1;
                     if (!r_write) begin
                        dmem_rdata <= r_mem[r_idx];
                     end
                  end
`else
                  dmem_resp <= 1'b1;
                  if (!r_write) begin
                     dmem_rdata <= r_mem[r_idx];
                  end
`endif
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // SRAM byte-lane writes; contents intentionally survive reset.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         if (r_be[0]) begin
            r_mem[r_idx][7:0] <= r_wdata[7:0];
         end
         if (r_be[1]) begin
            r_mem[r_idx][15:8] <= r_wdata[15:8];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Randomised self-checking bench for dmem_responder against an
//            array-based memory model and a cycle-count timing expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

   localparam int AB    = 8;
   localparam int LAT   = 2;
   localparam int DEPTH = 1 << AB;
`ifdef DMEM_RESPONDER_OOR_ERR_EN
   localparam bit OOR_EN = 1'b1;
`else
   localparam bit OOR_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        cyc;
   logic        stb;
   logic        wr;
   logic [1:0]  be;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        resp;
`ifdef DMEM_RESPONDER_OOR_ERR_EN
   logic        err;
`endif

   int          n_checks;
   int          n_errors;
   logic [15:0] mdl [0:DEPTH-1];
   logic [15:0] last_rdata;

   dmem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
      .clk              (clk),
      .rst              (rst),
      .dmem_action_cyc  (cyc),
      .dmem_action_stb  (stb),
      .dmem_write       (wr),
      .dmem_byte_enable (be),
      .dmem_address     (addr),
      .dmem_wdata       (wdata),
      .dmem_rdata       (rdata),
`ifdef DMEM_RESPONDER_OOR_ERR_EN
      .dmem_err         (err),
`endif
      .dmem_resp        (resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete request. Called at a negedge with the DUT idle; returns at
   // the negedge after the post-response idle edge, DUT idle again.
   task automatic do_req(input bit w, input logic [1:0] b, input logic [15:0] a,
                         input logic [15:0] d, input bit hold);
      bit          oor;
      int          idx;
      logic [15:0] exp_rd;
      oor = OOR_EN && ((a >> (AB + 1)) != 16'h0000);
      idx = int'(a >> 1) % DEPTH;
      cyc = 1'b1; stb = 1'b1; wr = w; be = b; addr = a; wdata = d;
      @(posedge clk);
      for (int k = 0; k <= LAT + 1; k++) begin
         @(negedge clk);
         if (k == LAT) begin
            if (oor) begin
               last_rdata = 16'h0000;
            end else if (w) begin
               if (b[0]) mdl[idx][7:0]  = d[7:0];
               if (b[1]) mdl[idx][15:8] = d[15:8];
            end else begin
               last_rdata = mdl[idx];
            end
         end
         exp_rd = last_rdata;
         check(k == LAT ? "resp_at_latency" : "resp_quiet", {31'd0, resp},
               {31'd0, (k == LAT) && !oor});
`ifdef DMEM_RESPONDER_OOR_ERR_EN
         check(k == LAT ? "err_at_latency" : "err_quiet", {31'd0, err},
               {31'd0, (k == LAT) && oor});
`endif
         check("rdata", {16'd0, rdata}, {16'd0, exp_rd});
         // Garbage on the bus while busy must be ignored.
         if (k <= LAT) begin
            stb = hold; wr = 1'($urandom); be = 2'($urandom);
            addr = 16'($urandom); wdata = 16'($urandom);
         end else begin
            stb = 1'b0;
         end
      end
   endtask

   // Accept a request, then drop cyc one cycle later: nothing may complete.
   task automatic do_abort(input bit w, input logic [1:0] b, input logic [15:0] a,
                           input logic [15:0] d);
      cyc = 1'b1; stb = 1'b1; wr = w; be = b; addr = a; wdata = d;
      @(posedge clk);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      for (int k = 0; k < LAT + 2; k++) begin
         @(negedge clk);
         check("abort_resp", {31'd0, resp}, 32'd0);
         check("abort_rdata", {16'd0, rdata}, {16'd0, last_rdata});
      end
      cyc = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] a;
      n_checks = 0; n_errors = 0; last_rdata = 16'h0000;
      rst = 1'b0; cyc = 1'b0; stb = 1'b0; wr = 1'b0; be = 2'b00;
      addr = 16'h0000; wdata = 16'h0000;
      #1 rst = 1'b1;
      #1;
      check("reset_resp", {31'd0, resp}, 32'd0);
      check("reset_rdata", {16'd0, rdata}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Give the SRAM known contents.
      for (int i = 0; i < DEPTH; i++) begin
         do_req(1'b1, 2'b11, 16'(i * 2), 16'h0000, 1'b0);
      end

      // Full write, read back.
      do_req(1'b1, 2'b11, 16'h0010, 16'hBEEF, 1'b0);
      do_req(1'b0, 2'b00, 16'h0010, 16'h0000, 1'b0);
      // High-byte-only write through odd address, then be=00 write.
      do_req(1'b1, 2'b10, 16'h0011, 16'h4400, 1'b0);
      do_req(1'b0, 2'b11, 16'h0010, 16'h0000, 1'b0);
      check("byte_merge", {16'd0, rdata}, 32'h44EF);
      do_req(1'b1, 2'b00, 16'h0010, 16'h1234, 1'b0);
      do_req(1'b0, 2'b00, 16'h0010, 16'h0000, 1'b0);
      check("be00_no_write", {16'd0, rdata}, 32'h44EF);

      // Indirect back-to-back with stb held through the response.
      do_req(1'b1, 2'b11, 16'h0020, 16'h0030, 1'b0);
      do_req(1'b1, 2'b11, 16'h0030, 16'h5A5A, 1'b0);
      do_req(1'b0, 2'b11, 16'h0020, 16'h0000, 1'b1);
      do_req(1'b0, 2'b11, 16'h0030, 16'h0000, 1'b0);
      check("indirect_second", {16'd0, rdata}, 32'h5A5A);

      // Abort leaves memory untouched.
      do_abort(1'b1, 2'b11, 16'h0040, 16'hFFFF);
      do_req(1'b0, 2'b11, 16'h0040, 16'h0000, 1'b0);
      check("abort_no_write", {16'd0, rdata}, 32'h0000);

      // Asynchronous reset in the middle of WAIT (rdata currently nonzero).
      do_req(1'b0, 2'b11, 16'h0010, 16'h0000, 1'b0);
      cyc = 1'b1; stb = 1'b1; wr = 1'b0; be = 2'b11; addr = 16'h0030;
      @(posedge clk);
      @(negedge clk);
      stb = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("async_rst_resp", {31'd0, resp}, 32'd0);
      check("async_rst_rdata", {16'd0, rdata}, 32'd0);
      last_rdata = 16'h0000;
      @(negedge clk);
      rst = 1'b0;
      do_req(1'b0, 2'b11, 16'h0010, 16'h0000, 1'b0);
      check("post_rst_read", {16'd0, rdata}, 32'h44EF);

`ifdef DMEM_RESPONDER_OOR_ERR_EN
      // Out-of-range write: err, no write into the aliased word.
      do_req(1'b1, 2'b11, 16'h0400, 16'hCAFE, 1'b0);
      do_req(1'b0, 2'b11, 16'h0000, 16'h0000, 1'b0);
      check("oor_alias_untouched", {16'd0, rdata}, 32'h0000);
      do_req(1'b0, 2'b11, 16'h0012, 16'h0000, 1'b0);
      do_req(1'b0, 2'b11, 16'h0400, 16'h0000, 1'b0);
`endif

      // Random traffic with occasional aborts.
      for (int n = 0; n < 300; n++) begin
         a = 16'($urandom);
         if (OOR_EN && $urandom_range(0, 3) != 0) a = a & 16'h01FF;
         if ($urandom_range(0, 9) == 0) begin
            do_abort(1'($urandom), 2'($urandom), a, 16'($urandom));
         end else begin
            do_req(1'($urandom), 2'($urandom), a, 16'($urandom), 1'($urandom));
         end
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
